// File: rtl/mm_pkg.sv
// ============================================================================
// Module      : mm_pkg
// Description : Shared state encoding, default geometry and width helpers
//               for the dot-product accumulator slice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mm_pkg;

    localparam int DEF_K    = 4;
    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;

    // Smallest accumulator that holds K full-range 32-bit products exactly.
    function automatic int acc_w_min(input int k);
        return 32 + $clog2(k);
    endfunction

    localparam int DEF_ACC_W = acc_w_min(DEF_K);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dot_accumulator_if.sv
// ============================================================================
// Module      : dot_accumulator_if
// Description : Product-in / sum-out handshake bundle for dot_accumulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dot_accumulator_if
    import mm_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int ACC_W = DEF_ACC_W
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic signed [31:0]      prod;
    logic                    prod_stb;
    logic                    in_ready;
    logic                    prod_ack;
    logic signed [ACC_W-1:0] sum;
    logic                    sum_stb;
    logic                    sum_ack;
    logic [RW-1:0]           row_idx;
    logic [CW-1:0]           col_idx;
    logic                    last_elem;

    modport slave (
        input  prod, prod_stb, sum_ack,
        output in_ready, prod_ack, sum, sum_stb, row_idx, col_idx, last_elem
    );

    modport master (
        output prod, prod_stb, sum_ack,
        input  in_ready, prod_ack, sum, sum_stb, row_idx, col_idx, last_elem
    );

endinterface

`default_nettype wire

// File: rtl/mm_idx_counter.sv
// ============================================================================
// Module      : mm_idx_counter
// Description : Row/column position of the current result element, advancing
//               in row-major order and wrapping at the matrix corner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mm_idx_counter
    import mm_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clear,
    input  wire logic          advance,
    output logic [RW-1:0]      row_idx,
    output logic [CW-1:0]      col_idx,
    output logic               last
);

    logic [RW-1:0] row_d, row_q;
    logic [CW-1:0] col_d, col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == CW'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_idx = row_q;
    assign col_idx = col_q;
    assign last    = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

endmodule

`default_nettype wire

// File: rtl/dot_accumulator.sv
// ============================================================================
// Module      : dot_accumulator
// Description : Sums K signed products per result element and hands each sum
//               downstream with row/column indices under a stb/ack handshake.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dot_accumulator
    import mm_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int ACC_W = DEF_ACC_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clear,
    dot_accumulator_if.slave  bus
);

    localparam int KW = $clog2(K);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_ACCUM = 2'(ST_ACCUM);
    localparam logic [1:0] S_OUT   = 2'(ST_OUT);

    if (K < 2) begin : g_k_check
        $error("dot_accumulator: K must be at least 2");
    end
    if (ACC_W < acc_w_min(K)) begin : g_acc_w_check
        $error("dot_accumulator: ACC_W too narrow for K full-range products");
    end

    logic [1:0]              state_d, state_q;
    logic [KW-1:0]           k_cnt_d, k_cnt_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic                    sum_stb_d, sum_stb_q;
    logic                    prod_ack_d, prod_ack_q;
    logic                    in_ready_w;
    logic                    consume_w;
    logic                    advance_w;
    logic                    idx_last_w;
    logic signed [ACC_W-1:0] prod_ext_w;

    assign in_ready_w = (state_q != S_OUT);
    assign consume_w  = bus.prod_stb && in_ready_w;
    assign prod_ext_w = ACC_W'(bus.prod);
    assign advance_w  = !clear && (state_q == S_OUT) && bus.sum_ack;

    always_comb begin
        state_d    = state_q;
        k_cnt_d    = k_cnt_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        sum_stb_d  = sum_stb_q;
        prod_ack_d = 1'b0;
        if (clear) begin
            // The sum register keeps its last value; only control state restarts.
            state_d   = S_IDLE;
            k_cnt_d   = '0;
            acc_d     = '0;
            sum_stb_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (consume_w) begin
                        prod_ack_d = 1'b1;
                        if (k_cnt_q == KW'(K - 1)) begin
                            sum_d     = acc_q + prod_ext_w;
                            sum_stb_d = 1'b1;
                            k_cnt_d   = '0;
                            state_d   = S_OUT;
                        end else begin
                            acc_d   = (k_cnt_q == '0) ? prod_ext_w : acc_q + prod_ext_w;
                            k_cnt_d = k_cnt_q + KW'(1);
                            state_d = S_ACCUM;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.sum_ack) begin
                        sum_stb_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_cnt_q    <= '0;
            acc_q      <= '0;
            sum_q      <= '0;
            sum_stb_q  <= 1'b0;
            prod_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_cnt_q    <= k_cnt_d;
            acc_q      <= acc_d;
            sum_q      <= sum_d;
            sum_stb_q  <= sum_stb_d;
            prod_ack_q <= prod_ack_d;
        end
    end

    mm_idx_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (advance_w),
        .row_idx (bus.row_idx),
        .col_idx (bus.col_idx),
        .last    (idx_last_w)
    );

    assign bus.in_ready  = in_ready_w;
    assign bus.prod_ack  = prod_ack_q;
    assign bus.sum       = sum_q;
    assign bus.sum_stb   = sum_stb_q;
    assign bus.last_elem = sum_stb_q && idx_last_w;

endmodule

`default_nettype wire

// File: tb/tb_dot_accumulator.sv
// ============================================================================
// Module      : tb_dot_accumulator
// Description : Directed and randomized checks of dot_accumulator against a
//               transaction-level model (product list -> element sums).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dot_accumulator;

    localparam int K     = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ACC_W = 34;

    logic clk;
    logic rst_n;
    logic clear;

    dot_accumulator_if #(.ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) bus ();

    dot_accumulator #(
        .K     (K),
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ACC_W (ACC_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending terms, one outstanding result, element number.
    int                      m_terms[$];
    bit                      m_pending;
    bit                      m_ack;
    int                      m_elem;
    logic signed [ACC_W-1:0] m_sum;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_terms.delete();
        m_pending = 1'b0;
        m_ack     = 1'b0;
        m_elem    = 0;
        m_sum     = '0;
    endtask

    task automatic check_outputs();
        int exp_row;
        int exp_col;
        exp_row = (m_elem / COLS) % ROWS;
        exp_col = m_elem % COLS;
        check("prod_ack", 64'(bus.prod_ack), 64'(m_ack));
        check("sum_stb", 64'(bus.sum_stb), 64'(m_pending));
        check("sum", 64'(bus.sum), 64'(m_sum));
        check("row_idx", 64'(bus.row_idx), 64'(exp_row));
        check("col_idx", 64'(bus.col_idx), 64'(exp_col));
        check("last_elem", 64'(bus.last_elem),
              64'(m_pending && exp_row == ROWS - 1 && exp_col == COLS - 1));
    endtask

    // Called at posedge+1; returns at the following posedge+1 after checking.
    task automatic step(input bit stb, input logic [31:0] p, input bit ack, input bit clr);
        longint total;
        bus.prod     = p;
        bus.prod_stb = stb;
        bus.sum_ack  = ack;
        clear        = clr;
        #2;
        check("in_ready", 64'(bus.in_ready), 64'(!m_pending));
        m_ack = 1'b0;
        if (clr) begin
            m_terms.delete();
            m_pending = 1'b0;
            m_elem    = 0;
        end else if (m_pending) begin
            if (ack) begin
                m_pending = 1'b0;
                m_elem++;
            end
        end else if (stb) begin
            m_terms.push_back(int'(p));
            m_ack = 1'b1;
            if (m_terms.size() == K) begin
                total = 0;
                foreach (m_terms[i]) total += longint'(m_terms[i]);
                m_sum     = total[ACC_W-1:0];
                m_pending = 1'b1;
                m_terms.delete();
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        bus.prod_stb = 1'b0;
        bus.sum_ack  = 1'b0;
        clear        = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        bus.prod     = '0;
        bus.prod_stb = 1'b0;
        bus.sum_ack  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_outputs();
        rst_n = 1'b1;

        // 1,2,3,4 with immediate acceptance -> 10 at (0,0)
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Four large negatives: exact 34-bit result, then held 5 cycles with stb high
        for (int i = 0; i < 4; i++) step(1'b1, 32'(-1073709056), 1'b0, 1'b0);
        check("big_neg_sum", 64'(bus.sum), 64'(-64'sd4294836224));
        for (int i = 0; i < 5; i++) step(1'b1, 32'(77), 1'b0, 1'b0);
        step(1'b1, 32'(77), 1'b1, 1'b0);
        check("col_after_ack", 64'(bus.col_idx), 64'd2);

        // Fill out the 4x4 matrix so last_elem fires and indices wrap
        while (m_elem < ROWS * COLS + 1) begin
            for (int i = 0; i < K; i++) step(1'b1, $urandom, 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Reset after two products, then 5,5,5,5 -> 20 at (0,0)
        step(1'b1, 32'(9), 1'b0, 1'b0);
        step(1'b1, 32'(9), 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'(5), 1'b0, 1'b0);
        check("reset_then_sum", 64'(bus.sum), 64'd20);
        step(1'b0, '0, 1'b1, 1'b0);

        // Clear on the third product, then 1,1,1,1 -> 4
        step(1'b1, 32'(3), 1'b0, 1'b0);
        step(1'b1, 32'(3), 1'b0, 1'b0);
        step(1'b1, 32'(3), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'(1), 1'b0, 1'b0);
        check("clear_then_sum", 64'(bus.sum), 64'd4);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic including mid-flight clears and a reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) async_reset();
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dot_accumulator.md
DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 SHALL have parameter K, default 4: number of products summed per output element (K >= 2).
REQ-002 SHALL have parameter ROWS, default 4: result-matrix rows.
REQ-003 SHALL have parameter COLS, default 4: result-matrix columns.
REQ-004 SHALL have parameter ACC_W, default 34: accumulator/sum width; elaboration error if ACC_W < 32 + clog2(K).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clear  input  1  synchronous abort/restart.
REQ-008 prod  input  32  signed product from upstream multiplier.
REQ-009 prod_stb  input  1  prod valid this cycle.
REQ-010 in_ready  output  1  block can consume a product this cycle.
REQ-011 prod_ack  output  1  registered pulse, high the cycle after a product was consumed.
REQ-012 sum  output  ACC_W  signed dot-product result.
REQ-013 sum_stb  output  1  sum/indices valid.
REQ-014 sum_ack  input  1  downstream accepts sum.
REQ-015 row_idx  output  clog2(ROWS)  row of current sum.
REQ-016 col_idx  output  clog2(COLS)  column of current sum.
REQ-017 last_elem  output  1  high with sum_stb when row_idx=ROWS-1 and col_idx=COLS-1.

Function
REQ-018 SHALL implement states IDLE, ACCUM, OUT.
REQ-019 in_ready SHALL be combinational: high in IDLE and ACCUM, low in OUT.
REQ-020 A product SHALL be consumed on each rising edge with prod_stb=1 and in_ready=1; prod_stb while in_ready=0 ignored.
REQ-021 Term counter k_cnt (0..K-1) SHALL increment per consumed product.
REQ-022 k_cnt=0 consume: acc <= sign-extended prod; state -> ACCUM.
REQ-023 0<k_cnt<K-1 consume: acc <= acc + sign-extended prod.
REQ-024 k_cnt=K-1 consume: sum <= acc + prod, sum_stb <= 1, k_cnt <= 0, state -> OUT; latency 1 cycle from final consume edge to sum_stb.
REQ-025 Arithmetic SHALL be two's complement modulo 2^ACC_W, no saturation, no overflow flag.
REQ-026 In OUT, sum, sum_stb, row_idx, col_idx, last_elem SHALL hold stable until sum_ack=1.
REQ-027 On OUT with sum_ack=1: sum_stb <= 0, state -> IDLE, col_idx increments; at COLS-1 wraps to 0 and row_idx increments; row_idx at ROWS-1 wraps to 0.
REQ-028 sum_ack outside OUT SHALL have no effect.
REQ-029 clear=1 SHALL override all other inputs: state IDLE, k_cnt/indices/acc 0, sum_stb 0, prod_ack 0; a product presented that cycle is discarded; sum register unchanged.
REQ-030 Throughput SHALL be one result per K+1 cycles minimum (K consumes + 1 OUT cycle with immediate sum_ack).

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state IDLE, sum 0, sum_stb 0, prod_ack 0, row_idx 0, col_idx 0, k_cnt 0, acc 0; last_elem 0, in_ready 1 follow.
REQ-032 Reset mid-accumulation or mid-OUT SHALL discard partial/pending sum; no output on release.

Structure
REQ-033 State encoding enum, default K/ROWS/COLS and ACC_W-minimum constant SHALL live in shared package mm_pkg.
REQ-034 Row/column index wrap logic SHALL be one sub-module, mm_idx_counter (advance input, row/col/last outputs).

Verification
REQ-035 Products 1,2,3,4 on consecutive cycles, sum_ack=1 -> sum=10, sum_stb one cycle after 4th consume, row/col=(0,0), prod_ack pulses 4 times.
REQ-036 Four products of -1073709056 -> sum=-4294836224 (34-bit exact, no wrap).
REQ-037 After sum_stb, sum_ack low 5 cycles with prod_stb=1 -> sum stable, in_ready=0, nothing consumed; sum_ack=1 -> IDLE, col_idx=1.
REQ-038 16 complete elements with 4x4 defaults -> last_elem only on 16th, indices return to (0,0).
REQ-039 rst_n low after 2 of 4 products, then products 5,5,5,5 -> single sum=20 at (0,0).
REQ-040 clear on cycle of 3rd product, then 1,1,1,1 -> sum=4, discarded product not included.
